mul_wb_buffer: RTL and testbench

- Consumes the M5 output of the multiply pipeline (valid, instruction type, pc, result, ROB id) and presents it on the shared ROB writeback port with a valid/ready handshake.
- The M pipeline cannot stall mid-flight, so results that lose writeback arbitration are held in a small FIFO.
- A credit-style stall output stops new issue into M1 before the FIFO can overflow.

---
 rtl/mul_wb_buffer_pkg.sv | 32 +++
 rtl/mul_wb_buffer_sync_fifo.sv | 86 ++++++++
 rtl/mul_wb_buffer.sv | 101 ++++++++++
 tb/tb_mul_wb_buffer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mul_wb_buffer_pkg.sv
// Shared multiply-pipeline types and constants for the M5 writeback buffer.
// WORD_SIZE / INSTR_TYPE_SZ come from the project-wide macros. When a macro
// is not defined, a local default is used instead.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif

package mul_wb_buffer_pkg;

    localparam int PKG_WORD_SIZE     = `WORD_SIZE;
    localparam int PKG_INSTR_TYPE_SZ = `INSTR_TYPE_SZ;

    // ROB tag width used across the backend
    localparam int ROB_ID_W = 7;

    // Number of multiply stages (M1..M5). At most this many results can
    // already be in flight when issue is stopped.
    localparam int M_STAGES  = 5;
    localparam int IN_FLIGHT = M_STAGES;

    // One writeback record as produced by M5
    typedef struct packed {
        logic [PKG_INSTR_TYPE_SZ-1:0] instr_type;
        logic [PKG_WORD_SIZE-1:0]     pc;
        logic [PKG_WORD_SIZE-1:0]     result;
        logic [ROB_ID_W-1:0]          rob_id;
    } mul_wb_entry_t;

endpackage

// File: rtl/mul_wb_buffer_sync_fifo.sv
// Show-ahead synchronous FIFO. The memory array is read into a registered
// head (dout). dout always presents the entry that is the head after the
// current edge. A write into an empty slot that becomes the head is forwarded
// from din. reset is active-low and synchronous. clear empties the FIFO and
// overrides push/pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    import mul_wb_buffer_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] dout_reg, dout_next;
    logic             push_ok, pop_ok;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign pop_ok  = pop && !empty && !clear;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok = push && !clear && (!full || pop_ok);

    assign dout  = dout_reg;
    assign count = count_reg;

    // Next pointer/count values; pointers wrap naturally (DEPTH is a power of two)
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (clear) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_ok) wr_ptr_next = wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_next = rd_ptr_reg + AW'(1);
            if (push_ok && !pop_ok)      count_next = count_reg + CW'(1);
            else if (!push_ok && pop_ok) count_next = count_reg - CW'(1);
        end
    end

    // Registered head: forward din when the slot being written becomes the head
    always_comb begin
        dout_next = mem[rd_ptr_next];
        if (push_ok && (wr_ptr_reg == rd_ptr_next)) dout_next = din;
    end

    // Storage array write port (no reset so it maps onto block RAM)
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
    end

    // Pointer, occupancy and head registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            dout_reg   <= dout_next;
        end
    end

endmodule

// File: rtl/mul_wb_buffer.sv
// Multiply-pipeline writeback buffer. It takes M5 results and holds them in a
// FIFO until the ROB writeback port accepts them with valid/ready. It also
// raises mul_stall early enough that every result already in flight still fits.
// Optional macro MUL_WB_BYPASS_EN: when the FIFO is empty, an incoming result is
// presented on wb_* in the same cycle. If it is granted in that cycle, it is
// never stored.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif

module mul_wb_buffer #(
    parameter int WORD_SIZE     = `WORD_SIZE,
    parameter int INSTR_TYPE_SZ = `INSTR_TYPE_SZ,
    parameter int ROB_ID_W      = mul_wb_buffer_pkg::ROB_ID_W,
    parameter int DEPTH         = 8,
    parameter int IN_FLIGHT     = mul_wb_buffer_pkg::IN_FLIGHT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       m_valid,
    input  logic [INSTR_TYPE_SZ-1:0]   m_instr_type,
    input  logic [WORD_SIZE-1:0]       m_pc,
    input  logic [WORD_SIZE-1:0]       m_result,
    input  logic [ROB_ID_W-1:0]        m_rob_id,
    input  logic                       flush,
    input  logic                       wb_ready,
    output logic                       wb_valid,
    output logic [INSTR_TYPE_SZ-1:0]   wb_instr_type,
    output logic [WORD_SIZE-1:0]       wb_pc,
    output logic [WORD_SIZE-1:0]       wb_result,
    output logic [ROB_ID_W-1:0]        wb_rob_id,
    output logic                       mul_stall,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);
    import mul_wb_buffer_pkg::*;

    localparam int EW = INSTR_TYPE_SZ + 2*WORD_SIZE + ROB_ID_W;
    localparam int CW = $clog2(DEPTH+1);

    logic [EW-1:0] m_entry;
    logic [EW-1:0] head_entry;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic          fifo_push, fifo_pop;
    logic          bypass_take;
    logic          overflow_reg, overflow_next;

    assign m_entry = {m_instr_type, m_pc, m_result, m_rob_id};

`ifdef MUL_WB_BYPASS_EN
    // An empty buffer presents the M5 result directly; flush and reset kill it
    assign bypass_take = reset && !flush && fifo_empty && m_valid;
`else
    assign bypass_take = 1'b0;
`endif

    // A bypassed result that is granted immediately is never stored
    assign fifo_push = m_valid && !flush && !(bypass_take && wb_ready);
    assign fifo_pop  = !fifo_empty && wb_ready && !flush;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (m_entry),
        .dout  (head_entry),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wb_valid = !fifo_empty || bypass_take;
    assign {wb_instr_type, wb_pc, wb_result, wb_rob_id} =
        bypass_take ? m_entry : head_entry;

    assign count     = fifo_count;
    assign mul_stall = (DEPTH - int'(fifo_count)) <= IN_FLIGHT;
    assign overflow  = overflow_reg;

    // Overflow latches when a result arrives at a full buffer that is not draining
    always_comb begin
        overflow_next = overflow_reg;
        if (m_valid && !flush && fifo_full && !fifo_pop) overflow_next = 1'b1;
    end

    // Sticky overflow register, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset) overflow_reg <= 1'b0;
        else        overflow_reg <= overflow_next;
    end

endmodule

// File: tb/tb_mul_wb_buffer.sv
// Directed, scoreboard-based bench for mul_wb_buffer. Expected entries are
// queued when a result is driven. They are popped and compared when the DUT
// hands them to the writeback port.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif

module tb_mul_wb_buffer;
    import mul_wb_buffer_pkg::*;

    localparam int DEPTH = 8;
    localparam int IFL   = 5;
    localparam int CW    = $clog2(DEPTH+1);
`ifdef MUL_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         m_valid;
    logic [PKG_INSTR_TYPE_SZ-1:0] m_instr_type;
    logic [PKG_WORD_SIZE-1:0]     m_pc;
    logic [PKG_WORD_SIZE-1:0]     m_result;
    logic [ROB_ID_W-1:0]          m_rob_id;
    logic                         flush;
    logic                         wb_ready;
    logic                         wb_valid;
    logic [PKG_INSTR_TYPE_SZ-1:0] wb_instr_type;
    logic [PKG_WORD_SIZE-1:0]     wb_pc;
    logic [PKG_WORD_SIZE-1:0]     wb_result;
    logic [ROB_ID_W-1:0]          wb_rob_id;
    logic                         mul_stall;
    logic [CW-1:0]                count;
    logic                         overflow;

    mul_wb_buffer #(
        .DEPTH     (DEPTH),
        .IN_FLIGHT (IFL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m_valid       (m_valid),
        .m_instr_type  (m_instr_type),
        .m_pc          (m_pc),
        .m_result      (m_result),
        .m_rob_id      (m_rob_id),
        .flush         (flush),
        .wb_ready      (wb_ready),
        .wb_valid      (wb_valid),
        .wb_instr_type (wb_instr_type),
        .wb_pc         (wb_pc),
        .wb_result     (wb_result),
        .wb_rob_id     (wb_rob_id),
        .mul_stall     (mul_stall),
        .count         (count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    mul_wb_entry_t sb[$];
    logic          ovf_exp = 1'b0;

    function automatic mul_wb_entry_t mk(input int rob);
        mul_wb_entry_t e;
        e.instr_type = PKG_INSTR_TYPE_SZ'(rob + 1);
        e.pc         = PKG_WORD_SIZE'(32'h0000_1000 + 4*rob);
        e.result     = PKG_WORD_SIZE'(32'hA5A5_0000 ^ (rob*rob));
        e.rob_id     = ROB_ID_W'(rob);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_entry(input string tag, input mul_wb_entry_t e);
        chk({tag, "_rob"},   64'(wb_rob_id),     64'(e.rob_id));
        chk({tag, "_pc"},    64'(wb_pc),         64'(e.pc));
        chk({tag, "_res"},   64'(wb_result),     64'(e.result));
        chk({tag, "_itype"}, 64'(wb_instr_type), 64'(e.instr_type));
    endtask

    // One clock: drive, check pre-edge handshake, update model, check post-edge
    task automatic cyc(input bit mv, input int rob, input bit rdy, input bit fl, input bit rst);
        mul_wb_entry_t e;
        int            sz;
        bit            byp, pop, taken;
        e            = mk(rob);
        m_valid      = mv;
        m_instr_type = e.instr_type;
        m_pc         = e.pc;
        m_result     = e.result;
        m_rob_id     = e.rob_id;
        wb_ready     = rdy;
        flush        = fl;
        reset        = rst;
        #2;
        sz  = sb.size();
        byp = BYP && rst && !fl && mv && (sz == 0);
        chk("pre_wb_valid", 64'(wb_valid), 64'((sz != 0) || byp));
        if (sz != 0)  chk_entry("head", sb[0]);
        else if (byp) chk_entry("bypass", e);
        if (rst && !fl && rdy && (sz != 0 || byp))
            $display("pop rob_id=%0d count=%0d", wb_rob_id, count);
        // reference model of the buffer
        if (!rst) begin
            sb.delete();
            ovf_exp = 1'b0;
        end else if (fl) begin
            sb.delete();
        end else begin
            pop   = (sz != 0) && rdy;
            taken = byp && rdy;
            if (pop) void'(sb.pop_front());
            if (mv && !taken) begin
                if (sz == DEPTH && !pop) ovf_exp = 1'b1;
                else                     sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        sz  = sb.size();
        byp = BYP && rst && !fl && mv && (sz == 0);
        chk("count",     64'(count),     64'(sz));
        chk("wb_valid",  64'(wb_valid),  64'((sz != 0) || byp));
        chk("overflow",  64'(overflow),  64'(ovf_exp));
        chk("mul_stall", 64'(mul_stall), 64'((DEPTH - sz) <= IFL));
        if (sz != 0) chk("post_head_rob", 64'(wb_rob_id), 64'(sb[0].rob_id));
        if (!rst) begin
            chk("rst_itype", 64'(wb_instr_type), 64'(0));
            chk("rst_pc",    64'(wb_pc),         64'(0));
            chk("rst_res",   64'(wb_result),     64'(0));
            chk("rst_rob",   64'(wb_rob_id),     64'(0));
        end
    endtask

    initial begin
        reset = 1'b0; m_valid = 1'b0; flush = 1'b0; wb_ready = 1'b0;
        m_instr_type = '0; m_pc = '0; m_result = '0; m_rob_id = '0;
        repeat (2) @(posedge clk);
        #1;
        // reset state
        cyc(0, 0, 0, 0, 0);
        // 1: basic flow with wb_ready held high
        cyc(1, 3, 1, 0, 1);
        cyc(1, 4, 1, 0, 1);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 0, 1);
        // 2: backpressure, head stays stable, then drain in order
        cyc(1, 10, 0, 0, 1);
        cyc(1, 11, 0, 0, 1);
        cyc(1, 12, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 1);
        // 3: stall threshold at count 2 -> 3, released by one pop
        cyc(1, 13, 0, 0, 1);
        cyc(1, 14, 0, 0, 1);
        cyc(1, 15, 0, 0, 1);
        cyc(0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 1);
        // 4: fill, push at full with pop, then push at full without pop
        for (int i = 0; i < DEPTH; i++) cyc(1, 30 + i, 0, 0, 1);
        cyc(1, 20, 1, 0, 1);
        cyc(1, 21, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        // 5: down to 5 entries, flush with a push, then reset with a push
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 1);
        cyc(1, 40, 1, 1, 1);
        cyc(0, 0, 1, 0, 1);
        cyc(1, 41, 1, 0, 0);
        cyc(0, 0, 0, 0, 1);
        // 6a: 20 results with an irregular grant pattern; pointers wrap
        for (int i = 0; i < 20; i++) cyc(1, 50 + i, (i % 4) != 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, (i % 2) == 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 1);
        // 6b: single result into an empty buffer with the grant already high
        cyc(1, 90, 1, 0, 1);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
